// File: rtl/otg_host_bus_sequencer_if.sv
// Purpose: groups the two requester ports and the ISP1362 host-port pins of the bus sequencer.
// Latency: none, wiring only.
// Backpressure: requests are held by the requester until its done pulse.
interface otg_host_bus_sequencer_if;
    logic        a_req;
    logic        a_we;
    logic [1:0]  a_addr;
    logic [15:0] a_wdata;
    logic        a_done;
    logic [15:0] a_rdata;
    logic        b_req;
    logic        b_we;
    logic [1:0]  b_addr;
    logic [15:0] b_wdata;
    logic        b_done;
    logic [15:0] b_rdata;
    logic        ready;
    logic        otg_cs_n;
    logic        otg_rd_n;
    logic        otg_wr_n;
    logic [1:0]  otg_addr;
    logic        otg_rst_n;
    logic [15:0] otg_dout;
    logic        otg_doe;
    logic [15:0] otg_din;
    logic        otg_int;
    logic        int_sync;

    // Sequencer side
    modport slave (
        input  a_req, a_we, a_addr, a_wdata, b_req, b_we, b_addr, b_wdata, otg_din, otg_int,
        output a_done, a_rdata, b_done, b_rdata, ready, otg_cs_n, otg_rd_n, otg_wr_n,
               otg_addr, otg_rst_n, otg_dout, otg_doe, int_sync
    );

    // Requester / pin-model side
    modport master (
        output a_req, a_we, a_addr, a_wdata, b_req, b_we, b_addr, b_wdata, otg_din, otg_int,
        input  a_done, a_rdata, b_done, b_rdata, ready, otg_cs_n, otg_rd_n, otg_wr_n,
               otg_addr, otg_rst_n, otg_dout, otg_doe, int_sync
    );
endinterface

// File: rtl/otg_host_bus_sequencer.sv
// Purpose: sequences ISP1362 host-port cycles for two round-robin requesters and runs the chip reset sequence.
// Latency: request seen in IDLE at cycle k -> done at k + T_SETUP + T_STROBE + T_HOLD + 1.
// Backpressure: requesters hold req and fields until done; requests wait in IDLE and are ignored until ready.
module otg_host_bus_sequencer #(
    parameter int unsigned T_SETUP     = 2,
    parameter int unsigned T_STROBE    = 4,
    parameter int unsigned T_HOLD      = 1,
    parameter int unsigned T_RECOVER   = 2,
    parameter int unsigned RST_CYCLES  = 500,
    parameter int unsigned WAKE_CYCLES = 2500
) (
    input  logic                      clk,
    input  logic                      reset_n,
    otg_host_bus_sequencer_if.slave   bus
);

    localparam int unsigned MAX_AB  = (T_SETUP > T_STROBE) ? T_SETUP : T_STROBE;
    localparam int unsigned MAX_CD  = (T_HOLD > T_RECOVER) ? T_HOLD : T_RECOVER;
    localparam int unsigned MAX_EF  = (RST_CYCLES > WAKE_CYCLES) ? RST_CYCLES : WAKE_CYCLES;
    localparam int unsigned MAX_ABC = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int unsigned MAX_ALL = (MAX_ABC > MAX_EF) ? MAX_ABC : MAX_EF;
    localparam int unsigned CW      = $clog2(MAX_ALL + 1);

    // Counters are loaded with (duration - 1) on state entry and count down to zero.
    localparam logic [CW-1:0] LD_SETUP   = CW'(T_SETUP - 1);
    localparam logic [CW-1:0] LD_STROBE  = CW'(T_STROBE - 1);
    localparam logic [CW-1:0] LD_HOLD    = CW'(T_HOLD - 1);
    localparam logic [CW-1:0] LD_RECOVER = CW'(T_RECOVER - 1);
    localparam logic [CW-1:0] LD_RST     = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0] LD_WAKE    = CW'(WAKE_CYCLES - 1);

    typedef enum logic [2:0] {
        RST_HOLD, RST_WAIT, IDLE, SETUP, STROBE, HOLD, RECOVER
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          expired;
    logic          grant_vld, grant_b, we_nxt, active_nxt;
    logic          prio_b;      // 1 = B wins the next tie
    logic          lat_b;       // port owning the access in flight
    logic          lat_we;
    logic          a_done, b_done, ready, int_meta, int_sync;
    logic          otg_cs_n, otg_rd_n, otg_wr_n, otg_rst_n, otg_doe;
    logic [1:0]    otg_addr;
    logic [15:0]   otg_dout, rdata;

    assign expired = (cnt == '0);

    // Next-state, phase counter and arbitration decision
    always_comb begin
        state_nxt = state;
        cnt_nxt   = expired ? cnt : cnt - 1'b1;
        grant_vld = 1'b0;
        grant_b   = 1'b0;
        case (state)
            RST_HOLD: if (expired) begin state_nxt = RST_WAIT; cnt_nxt = LD_WAKE;    end
            RST_WAIT: if (expired) begin state_nxt = IDLE;     cnt_nxt = '0;         end
            IDLE: begin
                if (bus.a_req || bus.b_req) begin
                    grant_vld = 1'b1;
                    grant_b   = bus.b_req && (!bus.a_req || prio_b);
                    state_nxt = SETUP;
                    cnt_nxt   = LD_SETUP;
                end
            end
            SETUP:    if (expired) begin state_nxt = STROBE;   cnt_nxt = LD_STROBE;  end
            STROBE:   if (expired) begin state_nxt = HOLD;     cnt_nxt = LD_HOLD;    end
            HOLD:     if (expired) begin state_nxt = RECOVER;  cnt_nxt = LD_RECOVER; end
            RECOVER:  if (expired) begin state_nxt = IDLE;     cnt_nxt = '0;         end
            default:  begin state_nxt = RST_HOLD; cnt_nxt = LD_RST; end
        endcase
        we_nxt = lat_we;
        if (grant_vld) begin
            we_nxt = grant_b ? bus.b_we : bus.a_we;
        end
        active_nxt = (state_nxt == SETUP) || (state_nxt == STROBE) || (state_nxt == HOLD);
    end

    // State register, phase counter and latched request ownership
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state  <= RST_HOLD;
            cnt    <= LD_RST;
            prio_b <= 1'b0;
            lat_b  <= 1'b0;
            lat_we <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (grant_vld) begin
                prio_b <= !grant_b;
                lat_b  <= grant_b;
                lat_we <= we_nxt;
            end
        end
    end

    // Pin and handshake outputs registered from the next state so the strobes are glitch-free
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            otg_cs_n  <= 1'b1;
            otg_rd_n  <= 1'b1;
            otg_wr_n  <= 1'b1;
            otg_addr  <= 2'b00;
            otg_rst_n <= 1'b0;
            otg_dout  <= 16'h0000;
            otg_doe   <= 1'b0;
            a_done    <= 1'b0;
            b_done    <= 1'b0;
            rdata     <= 16'h0000;
            ready     <= 1'b0;
        end else begin
            otg_cs_n  <= !active_nxt;
            otg_rd_n  <= !((state_nxt == STROBE) && !we_nxt);
            otg_wr_n  <= !((state_nxt == STROBE) && we_nxt);
            otg_doe   <= active_nxt && we_nxt;
            otg_rst_n <= (state_nxt != RST_HOLD);
            ready     <= (state_nxt != RST_HOLD) && (state_nxt != RST_WAIT);
            a_done    <= (state == HOLD) && (state_nxt == RECOVER) && !lat_b;
            b_done    <= (state == HOLD) && (state_nxt == RECOVER) && lat_b;
            if (grant_vld) begin
                otg_addr <= grant_b ? bus.b_addr : bus.a_addr;
                if (we_nxt) begin
                    otg_dout <= grant_b ? bus.b_wdata : bus.a_wdata;
                end
            end
            // Read data is captured on the edge that ends the last strobe cycle.
            if ((state == STROBE) && expired && !lat_we) begin
                rdata <= bus.otg_din;
            end
        end
    end

    // Two-flop synchroniser for the asynchronous interrupt line
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            int_meta <= 1'b0;
            int_sync <= 1'b0;
        end else begin
            int_meta <= bus.otg_int;
            int_sync <= int_meta;
        end
    end

    assign bus.a_done    = a_done;
    assign bus.b_done    = b_done;
    assign bus.a_rdata   = rdata;
    assign bus.b_rdata   = rdata;
    assign bus.ready     = ready;
    assign bus.otg_cs_n  = otg_cs_n;
    assign bus.otg_rd_n  = otg_rd_n;
    assign bus.otg_wr_n  = otg_wr_n;
    assign bus.otg_addr  = otg_addr;
    assign bus.otg_rst_n = otg_rst_n;
    assign bus.otg_dout  = otg_dout;
    assign bus.otg_doe   = otg_doe;
    assign bus.int_sync  = int_sync;

endmodule

// File: tb/tb_otg_host_bus_sequencer.sv
// Purpose: directed bench for the ISP1362 host-bus sequencer with immediate-assertion checks.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: requests are held until the matching done pulse, then dropped.
module tb_otg_host_bus_sequencer;

    logic clk = 1'b0;
    logic reset_n;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    otg_host_bus_sequencer_if bus();

    otg_host_bus_sequencer dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // Observation results of one access window
    int          cs_first, cs_cnt, stb_first, stb_cnt, other_stb, doe_bad, addr_bad, dout_bad;
    int          done_t, done_cnt, odone_cnt;
    logic [15:0] rdata_at_done;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts otg_rst_n low cycles, then cycles until ready; tracks cs_n and done activity meanwhile.
    task automatic wait_reset_seq(output int n_hold, output int n_wait, output int cs_low, output int dones);
        n_hold = 0; n_wait = 0; cs_low = 0; dones = 0;
        while (bus.otg_rst_n !== 1'b1 && n_hold < 4000) begin
            tick();
            n_hold++;
            if (bus.otg_cs_n !== 1'b1) cs_low++;
            if (bus.a_done === 1'b1 || bus.b_done === 1'b1) dones++;
        end
        while (bus.ready !== 1'b1 && n_wait < 4000) begin
            tick();
            n_wait++;
            if (bus.otg_cs_n !== 1'b1) cs_low++;
            if (bus.a_done === 1'b1 || bus.b_done === 1'b1) dones++;
        end
    endtask

    // Issues one access from an idle sequencer and observes 16 cycles of pin activity.
    task automatic access(input bit use_b, input bit we, input logic [1:0] addr, input logic [15:0] wdata);
        logic stb, ostb, mydone, odone;
        cs_first = -1; cs_cnt = 0; stb_first = -1; stb_cnt = 0; other_stb = 0;
        doe_bad = 0; addr_bad = 0; dout_bad = 0; done_t = -1; done_cnt = 0; odone_cnt = 0;
        rdata_at_done = 16'hxxxx;
        if (use_b) begin
            bus.b_req = 1'b1; bus.b_we = we; bus.b_addr = addr; bus.b_wdata = wdata;
        end else begin
            bus.a_req = 1'b1; bus.a_we = we; bus.a_addr = addr; bus.a_wdata = wdata;
        end
        for (int t = 1; t <= 16; t++) begin
            tick();
            if (bus.otg_cs_n === 1'b0) begin
                cs_cnt++;
                if (cs_first < 0) cs_first = t;
                if (bus.otg_addr !== addr) addr_bad++;
                if (we && bus.otg_dout !== wdata) dout_bad++;
            end
            if (bus.otg_doe !== (we && bus.otg_cs_n === 1'b0)) doe_bad++;
            stb  = we ? bus.otg_wr_n : bus.otg_rd_n;
            ostb = we ? bus.otg_rd_n : bus.otg_wr_n;
            if (stb === 1'b0) begin
                stb_cnt++;
                if (stb_first < 0) stb_first = t;
            end
            if (ostb !== 1'b1) other_stb++;
            mydone = use_b ? bus.b_done : bus.a_done;
            odone  = use_b ? bus.a_done : bus.b_done;
            if (mydone === 1'b1) begin
                done_cnt++;
                done_t = t;
                rdata_at_done = use_b ? bus.b_rdata : bus.a_rdata;
                if (use_b) bus.b_req = 1'b0; else bus.a_req = 1'b0;
            end
            if (odone !== 1'b0) odone_cnt++;
        end
    endtask

    task automatic check_access(input string p);
        check({p, "_cs_first"},  cs_first,  1);
        check({p, "_cs_cnt"},    cs_cnt,    7);
        check({p, "_stb_first"}, stb_first, 3);
        check({p, "_stb_cnt"},   stb_cnt,   4);
        check({p, "_other_stb"}, other_stb, 0);
        check({p, "_doe_bad"},   doe_bad,   0);
        check({p, "_addr_bad"},  addr_bad,  0);
        check({p, "_done_t"},    done_t,    8);
        check({p, "_done_cnt"},  done_cnt,  1);
        check({p, "_odone_cnt"}, odone_cnt, 0);
    endtask

    initial begin
        int n_hold, n_wait, cs_low, dones;
        int ord[4];
        int ndone, hi_run, min_gap, ngaps, low_seen, nwait, int_low;
        logic s1, s2, s3;

        reset_n = 1'b0;
        bus.a_req = 1'b0; bus.a_we = 1'b0; bus.a_addr = 2'b00; bus.a_wdata = 16'h0000;
        bus.b_req = 1'b0; bus.b_we = 1'b0; bus.b_addr = 2'b00; bus.b_wdata = 16'h0000;
        bus.otg_din = 16'hA5C3;
        bus.otg_int = 1'b1;

        // 1: reset values, then the chip reset sequence
        repeat (3) tick();
        check("rst_cs_n",      bus.otg_cs_n,  1'b1);
        check("rst_rd_n",      bus.otg_rd_n,  1'b1);
        check("rst_wr_n",      bus.otg_wr_n,  1'b1);
        check("rst_addr",      bus.otg_addr,  2'b00);
        check("rst_otg_rst_n", bus.otg_rst_n, 1'b0);
        check("rst_dout",      bus.otg_dout,  16'h0000);
        check("rst_doe",       bus.otg_doe,   1'b0);
        check("rst_a_done",    bus.a_done,    1'b0);
        check("rst_b_done",    bus.b_done,    1'b0);
        check("rst_rdata",     bus.a_rdata,   16'h0000);
        check("rst_ready",     bus.ready,     1'b0);
        check("rst_int_sync",  bus.int_sync,  1'b0);
        reset_n = 1'b1;
        wait_reset_seq(n_hold, n_wait, cs_low, dones);
        check("seq1_hold_cycles", n_hold, 500);
        check("seq1_wake_cycles", n_wait, 2500);
        check("seq1_cs_low",      cs_low, 0);
        check("seq1_int_sync",    bus.int_sync, 1'b1);

        // 2: port A write
        access(1'b0, 1'b1, 2'b01, 16'h0023);
        check_access("a_wr");
        check("a_wr_dout_bad", dout_bad, 0);
        check("a_wr_addr_kept", bus.otg_addr, 2'b01);

        // 3: port B read
        access(1'b1, 1'b0, 2'b00, 16'h0000);
        check_access("b_rd");
        check("b_rd_rdata", rdata_at_done, 16'hA5C3);

        // 4: both requesters held from reset release
        reset_n = 1'b0;
        bus.a_req = 1'b1; bus.a_we = 1'b0; bus.a_addr = 2'b10;
        bus.b_req = 1'b1; bus.b_we = 1'b0; bus.b_addr = 2'b11;
        repeat (2) tick();
        reset_n = 1'b1;
        wait_reset_seq(n_hold, n_wait, cs_low, dones);
        check("seq4_hold_cycles", n_hold, 500);
        check("seq4_wake_cycles", n_wait, 2500);
        check("seq4_cs_low",      cs_low, 0);
        check("seq4_dones",       dones,  0);
        ndone = 0; hi_run = 0; min_gap = 99; ngaps = 0; low_seen = 0; nwait = 0;
        while (ndone < 4 && nwait < 80) begin
            tick();
            nwait++;
            if (bus.otg_cs_n === 1'b0) begin
                if (low_seen != 0 && hi_run > 0) begin
                    ngaps++;
                    if (hi_run < min_gap) min_gap = hi_run;
                end
                low_seen = 1;
                hi_run = 0;
            end else begin
                hi_run++;
            end
            if (bus.a_done === 1'b1) begin ord[ndone] = 0; ndone++; end
            if (bus.b_done === 1'b1) begin ord[ndone] = 1; ndone++; end
        end
        bus.a_req = 1'b0;
        bus.b_req = 1'b0;
        check("arb_ndone", ndone, 4);
        check("arb_ord0",  ord[0], 0);
        check("arb_ord1",  ord[1], 1);
        check("arb_ord2",  ord[2], 0);
        check("arb_ord3",  ord[3], 1);
        check("arb_ngaps", ngaps, 3);
        check("arb_gap_ge3", (min_gap >= 3), 1);

        // 5: reset during the strobe of a write
        repeat (4) tick();
        bus.a_req = 1'b1; bus.a_we = 1'b1; bus.a_addr = 2'b11; bus.a_wdata = 16'hBEEF;
        repeat (4) tick();
        check("mid_wr_n_low", bus.otg_wr_n, 1'b0);
        check("mid_doe_high", bus.otg_doe,  1'b1);
        reset_n = 1'b0;
        tick();
        check("mid_rst_wr_n",      bus.otg_wr_n,  1'b1);
        check("mid_rst_cs_n",      bus.otg_cs_n,  1'b1);
        check("mid_rst_doe",       bus.otg_doe,   1'b0);
        check("mid_rst_otg_rst_n", bus.otg_rst_n, 1'b0);
        check("mid_rst_a_done",    bus.a_done,    1'b0);
        check("mid_rst_ready",     bus.ready,     1'b0);
        check("mid_rst_addr",      bus.otg_addr,  2'b00);
        bus.a_req = 1'b0;
        reset_n = 1'b1;
        wait_reset_seq(n_hold, n_wait, cs_low, dones);
        check("seq5_hold_cycles", n_hold, 500);
        check("seq5_wake_cycles", n_wait, 2500);
        check("seq5_dones",       dones,  0);

        // 6: one-cycle low pulse on the interrupt line
        check("int_idle", bus.int_sync, 1'b1);
        bus.otg_int = 1'b0;
        tick();
        s1 = bus.int_sync;
        bus.otg_int = 1'b1;
        tick();
        s2 = bus.int_sync;
        tick();
        s3 = bus.int_sync;
        int_low = 0;
        if (s1 === 1'b0) int_low++;
        if (s2 === 1'b0) int_low++;
        if (s3 === 1'b0) int_low++;
        check("int_t1", s1, 1'b1);
        check("int_t2", s2, 1'b0);
        check("int_t3", s3, 1'b1);
        check("int_low_cnt", int_low, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
